// File: rtl/vga_timing_pkg.sv
// Shared timing constants, the sync/bright bit bundle and configuration helpers
// for the VGA raster timing generator.
package vga_timing_pkg;

    localparam int DEF_CLK_DIV  = 4;
    localparam int DEF_CNT_W    = 10;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;

    typedef struct packed {
        logic hs;
        logic vs;
        logic br;
    } sync_bits_t;

    // Decode state at raster position (0,0): inside both sync pulses, not bright.
    localparam sync_bits_t SYNC_RST = '{hs: 1'b1, vs: 1'b1, br: 1'b0};

    function automatic int h_total(input int sync, input int bp, input int act, input int fp);
        return sync + bp + act + fp;
    endfunction

    function automatic int v_total(input int sync, input int bp, input int act, input int fp);
        return sync + bp + act + fp;
    endfunction

    function automatic int h_act_start(input int sync, input int bp);
        return sync + bp;
    endfunction

    function automatic int v_act_start(input int sync, input int bp);
        return sync + bp;
    endfunction

    function automatic bit cfg_ok(input int cnt_w, input int htot, input int vtot,
                                  input int clk_div, input int pipe_delay);
        longint lim;
        lim = longint'(1) << cnt_w;
        return (cnt_w >= 1) && (cnt_w <= 31) &&
               (longint'(htot) - 1 < lim) && (longint'(vtot) - 1 < lim) &&
               (clk_div >= 1) && (pipe_delay >= 0) && (pipe_delay <= 15);
    endfunction

endpackage

// File: rtl/vga_sync_delay.sv
// Pixel-tick shift register that lines hsync/vsync/bright up with a downstream
// pixel pipeline; depth 0 degenerates to a plain wire.
module vga_sync_delay
    import vga_timing_pkg::*;
#(
    parameter int DEPTH = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       adv,
    input  sync_bits_t din,
    output sync_bits_t dout
);

    if (DEPTH == 0) begin : g_wire
        logic unused_ok;
        assign unused_ok = clk ^ rst_n ^ adv;
        assign dout = din;
    end else begin : g_shift
        sync_bits_t stage [DEPTH];

        // Reset fills every stage with the (0,0) decode so no old frame leaks out.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int i = 0; i < DEPTH; i++) stage[i] <= SYNC_RST;
            end else if (adv) begin
                stage[0] <= din;
                for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
            end
        end

        assign dout = stage[DEPTH-1];
    end

endmodule

// File: rtl/vga_timing_gen.sv
// Single-clock VGA raster timing generator: clock-enable divider, h/v counters,
// registered sync/active decode, active-area coordinates and line/frame pulses.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int CLK_DIV    = DEF_CLK_DIV,
    parameter int CNT_W      = DEF_CNT_W,
    parameter int H_SYNC     = DEF_H_SYNC,
    parameter int H_BP       = DEF_H_BP,
    parameter int H_ACTIVE   = DEF_H_ACTIVE,
    parameter int H_FP       = DEF_H_FP,
    parameter int V_SYNC     = DEF_V_SYNC,
    parameter int V_BP       = DEF_V_BP,
    parameter int V_ACTIVE   = DEF_V_ACTIVE,
    parameter int V_FP       = DEF_V_FP,
    parameter bit HS_POL     = 1'b0,
    parameter bit VS_POL     = 1'b0,
    parameter int PIPE_DELAY = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    output logic             pix_en,
    output logic [CNT_W-1:0] hCount,
    output logic [CNT_W-1:0] vCount,
    output logic [CNT_W-1:0] pix_x,
    output logic [CNT_W-1:0] pix_y,
    output logic             hsync,
    output logic             vsync,
    output logic             bright,
    output logic             line_start,
    output logic             frame_start
);

    localparam int H_TOT = h_total(H_SYNC, H_BP, H_ACTIVE, H_FP);
    localparam int V_TOT = v_total(V_SYNC, V_BP, V_ACTIVE, V_FP);
    localparam int H_ST  = h_act_start(H_SYNC, H_BP);
    localparam int V_ST  = v_act_start(V_SYNC, V_BP);

    if (!cfg_ok(CNT_W, H_TOT, V_TOT, CLK_DIV, PIPE_DELAY)) begin : g_cfg_err
        $error("vga_timing_gen: CNT_W too narrow, CLK_DIV < 1 or PIPE_DELAY > 15");
    end

    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOT - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOT - 1);
    localparam logic [CNT_W-1:0] H_SYNC_C = CNT_W'(H_SYNC);
    localparam logic [CNT_W-1:0] V_SYNC_C = CNT_W'(V_SYNC);
    localparam logic [CNT_W-1:0] H_ST_C   = CNT_W'(H_ST);
    localparam logic [CNT_W-1:0] V_ST_C   = CNT_W'(V_ST);
    localparam logic [CNT_W-1:0] H_END_C  = CNT_W'(H_ST + H_ACTIVE - 1);
    localparam logic [CNT_W-1:0] V_END_C  = CNT_W'(V_ST + V_ACTIVE - 1);

    localparam int               DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_cnt;
    logic [CNT_W-1:0] h_next, v_next, x_next, y_next;
    logic             h_wrap, v_wrap, in_active;
    sync_bits_t       raw_q, raw_next, raw_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
        end else if (en) begin
            div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
        end
    end

    assign pix_en = en && (div_cnt == DIV_LAST);

    // Decodes are taken from the next position so the registered copies line up
    // with hCount/vCount in the same cycle.
    always_comb begin
        h_wrap      = (hCount == H_LAST);
        v_wrap      = (vCount == V_LAST);
        h_next      = h_wrap ? '0 : hCount + 1'b1;
        v_next      = vCount;
        if (h_wrap) begin
            v_next  = v_wrap ? '0 : vCount + 1'b1;
        end
        in_active   = (h_next >= H_ST_C) && (h_next <= H_END_C) &&
                      (v_next >= V_ST_C) && (v_next <= V_END_C);
        raw_next.hs = (h_next < H_SYNC_C);
        raw_next.vs = (v_next < V_SYNC_C);
        raw_next.br = in_active;
        x_next      = in_active ? h_next - H_ST_C : '0;
        y_next      = in_active ? v_next - V_ST_C : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hCount <= '0;
            vCount <= '0;
            pix_x  <= '0;
            pix_y  <= '0;
            raw_q  <= SYNC_RST;
        end else if (pix_en) begin
            hCount <= h_next;
            vCount <= v_next;
            pix_x  <= x_next;
            pix_y  <= y_next;
            raw_q  <= raw_next;
        end
    end

    // Pulses are one clk wide by construction and cannot re-fire while en is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            line_start  <= pix_en && h_wrap;
            frame_start <= pix_en && h_wrap && v_wrap;
        end
    end

    vga_sync_delay #(
        .DEPTH (PIPE_DELAY)
    ) u_sync_delay (
        .clk   (clk),
        .rst_n (rst_n),
        .adv   (pix_en),
        .din   (raw_q),
        .dout  (raw_d)
    );

    assign hsync  = raw_d.hs ? HS_POL : ~HS_POL;
    assign vsync  = raw_d.vs ? VS_POL : ~VS_POL;
    assign bright = raw_d.br;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Randomised-enable bench for vga_timing_gen: two small timing configurations,
// each checked cycle by cycle against a raster-position reference model.
module tb_vga_timing_gen;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic en    = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    typedef struct {
        int phase;
        int h;
        int v;
        int px;
        int py;
        int hs;
        int vs;
        int br;
        int ls;
        int fs;
    } exp_t;

    task automatic chk(input int cfg, input string name, input int act, input int expv);
        n_checks++;
        if (act != expv) begin
            n_errors++;
            $display("FAIL cfg%0d %s: got %0d, expected %0d (t=%0t)", cfg, name, act, expv, $time);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_cfg
        localparam int CD = (g == 0) ? 3 : 1;
        localparam int CW = (g == 0) ? 6 : 4;
        localparam int HS = (g == 0) ? 4 : 2;
        localparam int HB = (g == 0) ? 3 : 2;
        localparam int HA = (g == 0) ? 8 : 6;
        localparam int HF = (g == 0) ? 2 : 3;
        localparam int VS = (g == 0) ? 2 : 1;
        localparam int VB = 2;
        localparam int VA = (g == 0) ? 5 : 4;
        localparam int VF = 2;
        localparam int PD = (g == 0) ? 2 : 0;
        localparam bit HP = (g == 0);
        localparam bit VP = (g != 0);
        localparam int HT = HS + HB + HA + HF;
        localparam int VT = VS + VB + VA + VF;
        localparam int FT = HT * VT;

        logic          pix_en, hsync, vsync, bright, line_start, frame_start;
        logic [CW-1:0] hc, vc, px, py;

        vga_timing_gen #(
            .CLK_DIV (CD), .CNT_W (CW),
            .H_SYNC (HS), .H_BP (HB), .H_ACTIVE (HA), .H_FP (HF),
            .V_SYNC (VS), .V_BP (VB), .V_ACTIVE (VA), .V_FP (VF),
            .HS_POL (HP), .VS_POL (VP), .PIPE_DELAY (PD)
        ) u_dut (
            .clk (clk), .rst_n (rst_n), .en (en), .pix_en (pix_en),
            .hCount (hc), .vCount (vc), .pix_x (px), .pix_y (py),
            .hsync (hsync), .vsync (vsync), .bright (bright),
            .line_start (line_start), .frame_start (frame_start)
        );

        // Reference state: divider phase, linear raster position, and the
        // last PD undelayed decodes (oldest first) encoded as hs*4+vs*2+br.
        int   phase;
        int   pos;
        int   hist[$];
        exp_t exp_q[$];
        bit   armed = 1'b0;

        function automatic int decode(input int p);
            int h, v, hs, vs, br;
            h  = p % HT;
            v  = p / HT;
            hs = (h < HS) ? 1 : 0;
            vs = (v < VS) ? 1 : 0;
            br = (h >= HS + HB && h < HS + HB + HA && v >= VS + VB && v < VS + VB + VA) ? 1 : 0;
            return hs * 4 + vs * 2 + br;
        endfunction

        function automatic exp_t snapshot(input int ls, input int fs);
            exp_t e;
            int   r, d;
            r       = decode(pos);
            d       = (PD == 0) ? r : hist[0];
            e.phase = phase;
            e.h     = pos % HT;
            e.v     = pos / HT;
            e.px    = (r % 2 == 1) ? e.h - (HS + HB) : 0;
            e.py    = (r % 2 == 1) ? e.v - (VS + VB) : 0;
            e.hs    = ((d / 4) % 2 == 1) ? int'(HP) : int'(!HP);
            e.vs    = ((d / 2) % 2 == 1) ? int'(VP) : int'(!VP);
            e.br    = d % 2;
            e.ls    = ls;
            e.fs    = fs;
            return e;
        endfunction

        initial begin
            forever begin
                @(posedge clk or negedge rst_n);
                if (!rst_n) begin
                    phase = 0;
                    pos   = 0;
                    hist.delete();
                    for (int i = 0; i < PD; i++) hist.push_back(6);
                    exp_q.delete();
                    exp_q.push_back(snapshot(0, 0));
                    armed = 1'b1;
                end else begin
                    bit tick;
                    int ls, fs;
                    tick = en && (phase == CD - 1);
                    ls   = 0;
                    fs   = 0;
                    if (en) phase = (phase + 1) % CD;
                    if (tick) begin
                        if (PD > 0) begin
                            hist.push_back(decode(pos));
                            void'(hist.pop_front());
                        end
                        pos = (pos + 1) % FT;
                        ls  = (pos % HT == 0) ? 1 : 0;
                        fs  = (pos == 0) ? 1 : 0;
                    end
                    exp_q.push_back(snapshot(ls, fs));
                end
            end
        end

        initial begin
            exp_t e;
            forever begin
                @(negedge clk);
                if (armed) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_errors++;
                        $display("FAIL cfg%0d queue: no expected entry at t=%0t", g, $time);
                    end else begin
                        e = exp_q.pop_front();
                        chk(g, "pix_en", int'(pix_en), (en && e.phase == CD - 1) ? 1 : 0);
                        chk(g, "hCount", int'(hc), e.h);
                        chk(g, "vCount", int'(vc), e.v);
                        chk(g, "pix_x", int'(px), e.px);
                        chk(g, "pix_y", int'(py), e.py);
                        chk(g, "hsync", int'(hsync), e.hs);
                        chk(g, "vsync", int'(vsync), e.vs);
                        chk(g, "bright", int'(bright), e.br);
                        chk(g, "line_start", int'(line_start), e.ls);
                        chk(g, "frame_start", int'(frame_start), e.fs);
                    end
                end
            end
        end
    end

    task automatic drive_const(input bit v, input int n);
        repeat (n) begin
            @(posedge clk);
            #2 en = v;
        end
    endtask

    task automatic drive_random(input int n);
        repeat (n) begin
            @(posedge clk);
            #2 en = ($urandom_range(0, 9) < 7);
        end
    endtask

    // Short asynchronous reset pulse, with an immediate look at cfg0 outputs.
    task automatic reset_pulse();
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk(0, "rst_async_hCount", int'(g_cfg[0].hc), 0);
        chk(0, "rst_async_vCount", int'(g_cfg[0].vc), 0);
        chk(0, "rst_async_pix_x", int'(g_cfg[0].px), 0);
        chk(0, "rst_async_hsync", int'(g_cfg[0].hsync), 1);
        chk(0, "rst_async_vsync", int'(g_cfg[0].vsync), 0);
        chk(0, "rst_async_bright", int'(g_cfg[0].bright), 0);
        #2 rst_n = 1'b1;
    endtask

    initial begin
        int budget;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        en = 1'b1;

        drive_const(1'b1, 1150);
        drive_random(1500);
        drive_const(1'b1, 50);
        drive_const(1'b0, 37);
        drive_const(1'b1, 100);

        budget = 0;
        while (!(g_cfg[0].bright === 1'b1) && budget < 2000) begin
            @(posedge clk);
            #2 budget++;
        end
        if (budget >= 2000) begin
            n_checks++;
            n_errors++;
            $display("FAIL bright_wait: no active pixel within %0d cycles", budget);
        end
        drive_const(1'b1, 3);
        reset_pulse();
        drive_const(1'b1, 700);
        drive_random(200);

        @(negedge clk);
        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
